// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field positions, fetch state encoding and default reset PC.
// S_ERR exists only when IFETCH_ALIGN_CHECK_EN is defined.
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    S_ERR  = 2'd3
`endif
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and memory (slave).
interface instruction_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  import mips_pkg::*;

  logic                o_imem_req;
  logic [ADDR_W-1:0]   o_imem_addr;
  logic                i_imem_ack;
  logic [INSTR_W-1:0]  i_imem_rdata;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_ack,
    input  i_imem_rdata
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_ack,
    output i_imem_rdata
  );

endinterface

// File: rtl/instr_field_splitter.sv
// Combinational split of a MIPS instruction word into its R/I-type fields.
module instr_field_splitter
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output logic [5:0]         o_opcode,
  output logic [4:0]         o_rs,
  output logic [4:0]         o_rt,
  output logic [4:0]         o_rd,
  output logic [4:0]         o_shamt,
  output logic [5:0]         o_funct,
  output logic [15:0]        o_imm16
);

  assign o_opcode = i_instr[OPC_HI:OPC_LO];
  assign o_rs     = i_instr[RS_HI:RS_LO];
  assign o_rt     = i_instr[RT_HI:RT_LO];
  assign o_rd     = i_instr[RD_HI:RD_LO];
  assign o_shamt  = i_instr[SHAMT_HI:SHAMT_LO];
  assign o_funct  = i_instr[FUNCT_HI:FUNCT_LO];
  assign o_imm16  = i_instr[IMM_HI:IMM_LO];

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC, req/ack fetch from instruction memory, instruction register to decode.
// Optional misaligned-redirect trap enabled by IFETCH_ALIGN_CHECK_EN.
//
// state  | meaning
// S_IDLE | bubble cycle after reset, no request
// S_REQ  | request outstanding at PC, waiting for ack
// S_HOLD | instruction register valid, waiting for decode ready
// S_ERR  | misaligned redirect seen, fetch halted (align-check build only)
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  instruction_fetch_unit_if.master imem,
  input  logic                 i_redirect,
  input  logic [ADDR_W-1:0]    i_redirect_pc,
  input  logic                 i_instr_ready,
  output logic                 o_instr_valid,
  output logic [INSTR_W-1:0]   o_instr,
  output logic [ADDR_W-1:0]    o_pc,
  output logic [ADDR_W-1:0]    o_pc_plus4,
  output logic [5:0]           o_opcode,
  output logic [4:0]           o_rs,
  output logic [4:0]           o_rt,
  output logic [4:0]           o_rd,
  output logic [4:0]           o_shamt,
  output logic [5:0]           o_funct,
  output logic [15:0]          o_imm16
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic                 o_misaligned
`endif
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_instr_pc;
  logic [INSTR_W-1:0]  r_instr;
  logic                w_capture;
  logic                w_advance;
  logic                w_req;
  logic                w_valid;
  logic                w_redir_bad;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic                r_misaligned;
  assign w_redir_bad = |i_redirect_pc[1:0];
  assign o_misaligned = r_misaligned;
`else
  logic                w_unused_redir_lsb;
  assign w_redir_bad = 1'b0;
  assign w_unused_redir_lsb = ^i_redirect_pc[1:0];
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    w_req       = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        w_req = 1'b1;
        if (imem.i_imem_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        w_valid = 1'b1;
        if (i_instr_ready) begin
          w_advance   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = r_state;
    endcase
    // Redirect wins over any same-cycle ack or ready.
    if (i_redirect) begin
      w_capture = 1'b0;
      w_advance = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      w_state_nxt = w_redir_bad ? S_ERR : S_REQ;
`else
      w_state_nxt = S_REQ;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= RESET_PC;
    end else begin
      if (i_redirect) begin
        if (!w_redir_bad) r_pc <= {i_redirect_pc[ADDR_W-1:2], 2'b00};
      end else if (w_advance) begin
        r_pc <= r_pc + ADDR_W'(4);
      end
      if (w_capture) begin
        r_instr    <= imem.i_imem_rdata;
        r_instr_pc <= r_pc;
      end
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)        r_misaligned <= 1'b0;
    else if (i_redirect) r_misaligned <= w_redir_bad;
  end
`endif

  assign imem.o_imem_req  = w_req;
  assign imem.o_imem_addr = r_pc;
  assign o_instr_valid    = w_valid;
  assign o_instr          = r_instr;
  assign o_pc             = r_instr_pc;
  assign o_pc_plus4       = r_instr_pc + ADDR_W'(4);

  instr_field_splitter u_splitter (
    .i_instr  (r_instr),
    .o_opcode (o_opcode),
    .o_rs     (o_rs),
    .o_rt     (o_rt),
    .o_rd     (o_rd),
    .o_shamt  (o_shamt),
    .o_funct  (o_funct),
    .o_imm16  (o_imm16)
  );

endmodule
